tinyml_cmd_issuer: RTL

//  Hardware initiator for the tinyML custom-instruction interface (cmd_*/rsp_*).

---
 rtl/tinyml_cmd_issuer_if.sv | 26 ++
 rtl/tinyml_cmd_issuer.sv | 129 ++++++++++++
 2 files changed

// File: rtl/tinyml_cmd_issuer_if.sv
// Custom-instruction command/response bus between an issuer and an accelerator.
interface tinyml_cmd_issuer_if;
    localparam int unsigned FID_W  = 10;
    localparam int unsigned DATA_W = 32;

    logic              cmd_valid;
    logic [FID_W-1:0]  cmd_function_id;
    logic [DATA_W-1:0] cmd_inputs_0;
    logic [DATA_W-1:0] cmd_inputs_1;
    logic              cmd_ready;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_outputs_0;
    logic              rsp_ready;

    // Issuer side
    modport master (
        output cmd_valid, cmd_function_id, cmd_inputs_0, cmd_inputs_1, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_outputs_0
    );

    // Accelerator side
    modport slave (
        input  cmd_valid, cmd_function_id, cmd_inputs_0, cmd_inputs_1, rsp_ready,
        output cmd_ready, rsp_valid, rsp_outputs_0
    );
endinterface

// File: rtl/tinyml_cmd_issuer.sv
// tinyml_cmd_issuer: runs one custom-instruction op per request without the CPU.
// Optional command timeout abort enabled by defining TINYML_CMD_TIMEOUT_EN.
module tinyml_cmd_issuer #(
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter int unsigned CNT_W          = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [9:0]        req_function_id,
    input  logic [31:0]       req_inputs_0,
    input  logic [31:0]       req_inputs_1,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [31:0]       res_data,
    output logic              res_timeout,
    tinyml_cmd_issuer_if.master cmd,
    output logic              busy,
    output logic [CNT_W-1:0]  cmd_count
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t state;
    logic   accept;
    logic   expired;

    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be nonzero");
    end

    assign accept = (state == IDLE) & req_valid & req_ready;

    // Response is taken while waiting, or together with command acceptance
    assign cmd.rsp_ready = (state == WAIT) | ((state == ISSUE) & cmd.cmd_ready);

`ifdef TINYML_CMD_TIMEOUT_EN
    localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TMO_W-1:0] tmo_cnt;

    // Cycles spent in ISSUE+WAIT for the current command
    always_ff @(posedge clk) begin
        if (reset || accept) begin
            tmo_cnt <= '0;
        end else if (state == ISSUE || state == WAIT) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

    assign expired = (state == ISSUE || state == WAIT) &&
                     (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign expired = 1'b0;
`endif

    // Issue FSM with registered outputs; a response always beats a timeout
    always_ff @(posedge clk) begin
        if (reset) begin
            state               <= IDLE;
            req_ready           <= 1'b0;
            busy                <= 1'b0;
            cmd.cmd_valid       <= 1'b0;
            cmd.cmd_function_id <= '0;
            cmd.cmd_inputs_0    <= '0;
            cmd.cmd_inputs_1    <= '0;
            res_valid           <= 1'b0;
            res_data            <= '0;
            res_timeout         <= 1'b0;
            cmd_count           <= '0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (accept) begin
                        cmd.cmd_function_id <= req_function_id;
                        cmd.cmd_inputs_0    <= req_inputs_0;
                        cmd.cmd_inputs_1    <= req_inputs_1;
                        cmd.cmd_valid       <= 1'b1;
                        req_ready           <= 1'b0;
                        busy                <= 1'b1;
                        state               <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (cmd.cmd_ready && cmd.rsp_valid) begin
                        cmd.cmd_valid <= 1'b0;
                        res_valid     <= 1'b1;
                        res_data      <= cmd.rsp_outputs_0;
                        res_timeout   <= 1'b0;
                        cmd_count     <= cmd_count + CNT_W'(1);
                        state         <= DONE;
                    end else if (expired) begin
                        cmd.cmd_valid <= 1'b0;
                        res_valid     <= 1'b1;
                        res_data      <= '0;
                        res_timeout   <= 1'b1;
                        state         <= DONE;
                    end else if (cmd.cmd_ready) begin
                        cmd.cmd_valid <= 1'b0;
                        state         <= WAIT;
                    end
                end
                WAIT: begin
                    if (cmd.rsp_valid) begin
                        res_valid   <= 1'b1;
                        res_data    <= cmd.rsp_outputs_0;
                        res_timeout <= 1'b0;
                        cmd_count   <= cmd_count + CNT_W'(1);
                        state       <= DONE;
                    end else if (expired) begin
                        res_valid   <= 1'b1;
                        res_data    <= '0;
                        res_timeout <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
